// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : In-flight write tracker beside the ID stage. Produces the ID
//             stall, per-operand bypass selects and a saturating stall count.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH  = 3,   // tracked stages after ID (0 = EXE)
    parameter int REG_AW = 3,   // register address width
    parameter int LAT_W  = 2,   // ready-stage field width
    parameter int FWD_W  = 2,   // bypass select width, 2^FWD_W >= DEPTH+1
    parameter int CNT_W  = 16   // stall counter width
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [LAT_W-1:0]  issue_ready,
    input  logic              flush,
    input  logic              rs1_use,
    input  logic              rs2_use,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              stall,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    // Per-entry state: valid/write flags are reset, payload is don't-care
    // whenever the entry is not a live write.
    logic [DEPTH-1:0]  r_v;
    logic [DEPTH-1:0]  r_wr;
    logic [REG_AW-1:0] r_rd    [DEPTH];
    logic [LAT_W-1:0]  r_ready [DEPTH];
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_nrdy_a;
    logic              w_nrdy_b;
    logic [FWD_W-1:0]  w_fwd_a;
    logic [FWD_W-1:0]  w_fwd_b;
    logic              w_stall;

    // Youngest-first producer search for both operands; first hit wins.
    always_comb begin
        logic w_hit_a;
        logic w_hit_b;
        w_hit_a  = 1'b0;
        w_hit_b  = 1'b0;
        w_nrdy_a = 1'b0;
        w_nrdy_b = 1'b0;
        w_fwd_a  = '0;
        w_fwd_b  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!w_hit_a && rs1_use && r_v[k] && r_wr[k] && (r_rd[k] == rs1)) begin
                w_hit_a = 1'b1;
                if (k >= int'(r_ready[k])) begin
                    w_fwd_a = FWD_W'(k + 1);
                end else begin
                    w_nrdy_a = 1'b1;
                end
            end
            if (!w_hit_b && rs2_use && r_v[k] && r_wr[k] && (r_rd[k] == rs2)) begin
                w_hit_b = 1'b1;
                if (k >= int'(r_ready[k])) begin
                    w_fwd_b = FWD_W'(k + 1);
                end else begin
                    w_nrdy_b = 1'b1;
                end
            end
        end
    end

    // Only an instruction actually trying to issue can be held; flush does
    // not mask the stall, it only prevents the issue from being recorded.
    assign w_stall = issue_valid & (w_nrdy_a | w_nrdy_b);

    // Control bits of the shift chain; entry 0 takes the issue or a bubble.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v  <= '0;
            r_wr <= '0;
        end else begin
            r_v[0]  <= issue_valid & ~w_stall & ~flush;
            r_wr[0] <= issue_wr;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k]  <= r_v[k-1];
                r_wr[k] <= r_wr[k-1];
            end
        end
    end

    // Payload of the shift chain; meaningful only alongside a set valid bit.
    always_ff @(posedge clk) begin
        r_rd[0]    <= issue_rd;
        r_ready[0] <= issue_ready;
        for (int k = 1; k < DEPTH; k++) begin
            r_rd[k]    <= r_rd[k-1];
            r_ready[k] <= r_ready[k-1];
        end
    end

    // Saturating count of cycles in which ID was held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall       = w_stall;
    assign fwd_a       = w_fwd_a;
    assign fwd_b       = w_fwd_b;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Self-checking bench: directed vector table, deep/narrow-counter
//             corner sequences, and randomized traffic against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int c_DEPTH = 3;
    localparam int c_NRAND = 400;

    // ---------------- DUT 1: default parameters ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid, issue_wr, flush, rs1_use, rs2_use;
    logic [2:0]  issue_rd, rs1, rs2;
    logic [1:0]  issue_ready;
    logic        stall;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    hazard_scoreboard u_dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .flush(flush),
        .rs1_use(rs1_use), .rs2_use(rs2_use), .rs1(rs1), .rs2(rs2),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    // ---------------- DUT 2: DEPTH 5, 2-bit counter ----------------
    logic        d2_rst_n;
    logic        d2_valid, d2_wr, d2_flush, d2_u1, d2_u2;
    logic [2:0]  d2_rd, d2_rs1, d2_rs2;
    logic [1:0]  d2_ready;
    logic        d2_stall;
    logic [2:0]  d2_fwd_a, d2_fwd_b;
    logic [1:0]  d2_cnt;

    hazard_scoreboard #(.DEPTH(5), .REG_AW(3), .LAT_W(2), .FWD_W(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset_n(d2_rst_n),
        .issue_valid(d2_valid), .issue_wr(d2_wr), .issue_rd(d2_rd),
        .issue_ready(d2_ready), .flush(d2_flush),
        .rs1_use(d2_u1), .rs2_use(d2_u2), .rs1(d2_rs1), .rs2(d2_rs2),
        .stall(d2_stall), .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b), .stall_count(d2_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       v, wr;
        logic [2:0] rd;
        logic [1:0] rdy;
        logic       fl, u1;
        logic [2:0] rs1;
        logic       u2;
        logic [2:0] rs2;
    } in_t;

    // Expected values of -1 mean "not checked" (fwd of a not-ready operand).
    typedef struct {
        in_t i;
        int  st, fa, fb, cnt;
    } vec_t;

    typedef struct {
        bit v, wr;
        int rd, ready;
    } rec_t;

    vec_t tbl [20];
    rec_t q [$];      // in-flight instructions, index = age in cycles (0 = EXE)
    int   m_cnt;

    function automatic vec_t mk(int v, int wr, int rd, int rdy, int fl,
                                int u1, int r1, int u2, int r2,
                                int st, int fa, int fb, int cnt);
        vec_t x;
        x.i.v = v[0]; x.i.wr = wr[0]; x.i.rd = rd[2:0]; x.i.rdy = rdy[1:0];
        x.i.fl = fl[0]; x.i.u1 = u1[0]; x.i.rs1 = r1[2:0];
        x.i.u2 = u2[0]; x.i.rs2 = r2[2:0];
        x.st = st; x.fa = fa; x.fb = fb; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        if (exp < 0) return;
        n_checks++;
        if (act !== exp[31:0]) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t x);
        issue_valid = x.v;  issue_wr = x.wr; issue_rd = x.rd; issue_ready = x.rdy;
        flush = x.fl; rs1_use = x.u1; rs1 = x.rs1; rs2_use = x.u2; rs2 = x.rs2;
    endtask

    function automatic in_t rand_in();
        in_t x;
        x.v   = ($urandom_range(0, 3) != 0);
        x.wr  = ($urandom_range(0, 3) != 0);
        x.rd  = 3'($urandom_range(0, 7));
        x.rdy = 2'($urandom_range(0, 9) < 6 ? 0 : $urandom_range(1, 3));
        x.fl  = ($urandom_range(0, 7) == 0);
        x.u1  = ($urandom_range(0, 3) != 0);
        x.rs1 = 3'($urandom_range(0, 7));
        x.u2  = ($urandom_range(0, 1) != 0);
        x.rs2 = 3'($urandom_range(0, 7));
        return x;
    endfunction

    // Find the youngest in-flight write of rs; report its bypass source, or
    // that it is still being computed (fwd = -1, not ready).
    function automatic void m_lookup(input bit use_i, input int rs,
                                     output int fwd, output bit nrdy);
        fwd = 0; nrdy = 1'b0;
        if (!use_i) return;
        for (int age = 0; age < q.size(); age++) begin
            if (q[age].v && q[age].wr && q[age].rd == rs) begin
                if (age >= q[age].ready) fwd = age + 1;
                else begin fwd = -1; nrdy = 1'b1; end
                return;
            end
        end
    endfunction

    task automatic d2_cyc(input int v, input int wr, input int rd, input int rdy,
                          input int u1, input int r1,
                          input int st, input int fa, input int cnt, input string tag);
        d2_valid = v[0]; d2_wr = wr[0]; d2_rd = rd[2:0]; d2_ready = rdy[1:0];
        d2_u1 = u1[0]; d2_rs1 = r1[2:0];
        @(negedge clk);
        chk({tag, " stall"}, 32'(d2_stall), st);
        chk({tag, " fwd_a"}, 32'(d2_fwd_a), fa);
        chk({tag, " count"}, 32'(d2_cnt), cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        // ------------------ directed table (DUT 1) ------------------
        //              v wr rd rdy fl u1 rs1 u2 rs2   st  fa  fb cnt
        tbl[0]  = mk(1, 1, 2, 0, 0, 1, 3, 0, 0,    0,  0,  0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 1, 2, 1, 2,    0,  1,  1, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1, 2, 0, 0,    0,  2,  0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 2, 0, 0,    0,  3,  0, 0);
        tbl[4]  = mk(1, 1, 5, 1, 0, 1, 2, 0, 0,    0,  0,  0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 5,    1,  0, -1, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 5,    0,  0,  2, 1);
        tbl[7]  = mk(1, 1, 4, 0, 0, 0, 0, 0, 0,    0,  0,  0, 1);
        tbl[8]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0,    0,  0,  0, 1);
        tbl[9]  = mk(1, 1, 4, 0, 0, 1, 4, 0, 0,    0,  2,  0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 4, 1, 7,    0,  1,  2, 1);
        tbl[11] = mk(1, 1, 6, 0, 1, 0, 0, 0, 0,    0,  0,  0, 1);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 6, 1, 6,    0,  0,  0, 1);
        tbl[13] = mk(1, 1, 3, 1, 0, 0, 0, 0, 0,    0,  0,  0, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 3, 0, 0,    0, -1,  0, 1);
        tbl[15] = mk(1, 1, 3, 1, 0, 1, 3, 0, 0,    0,  2,  0, 1);
        tbl[16] = mk(1, 0, 0, 0, 1, 1, 3, 0, 0,    1, -1,  0, 1);
        tbl[17] = mk(1, 0, 0, 0, 0, 1, 3, 0, 0,    0,  2,  0, 2);
        tbl[18] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0,    0,  0,  0, 2);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0,    0,  0,  1, 2);

        d2_rst_n = 1'b0; d2_valid = 0; d2_wr = 0; d2_rd = 0; d2_ready = 0;
        d2_flush = 0; d2_u1 = 0; d2_u2 = 0; d2_rs1 = 0; d2_rs2 = 0;

        // Reset with random inputs, checked while still in reset.
        reset_n = 1'b0;
        drive(rand_in());
        repeat (2) @(posedge clk);
        #1 drive(rand_in());
        @(negedge clk);
        chk("reset stall", 32'(stall), 0);
        chk("reset fwd_a", 32'(fwd_a), 0);
        chk("reset fwd_b", 32'(fwd_b), 0);
        chk("reset count", 32'(stall_count), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].i);
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), 32'(stall), tbl[i].st);
            chk($sformatf("vec%0d fwd_a", i), 32'(fwd_a), tbl[i].fa);
            chk($sformatf("vec%0d fwd_b", i), 32'(fwd_b), tbl[i].fb);
            chk($sformatf("vec%0d count", i), 32'(stall_count), tbl[i].cnt);
            @(posedge clk); #1;
        end

        // Mid-operation reset: the r0 write still in flight must be forgotten.
        reset_n = 1'b0;
        drive(rand_in());
        @(posedge clk); #1 drive(rand_in());
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0).i);
        @(negedge clk);
        chk("post-reset stall", 32'(stall), 0);
        chk("post-reset fwd_a", 32'(fwd_a), 0);
        chk("post-reset fwd_b", 32'(fwd_b), 0);
        chk("post-reset count", 32'(stall_count), 0);

        // ------------------ randomized traffic (DUT 1) ------------------
        // The issue driven above is a non-writer; it is entry 0 next cycle.
        q.delete();
        for (int k = 0; k < c_DEPTH; k++) q.push_back('{v: 1'b0, wr: 1'b0, rd: 0, ready: 0});
        m_cnt = 0;
        begin
            rec_t r;
            r.v = 1'b1; r.wr = 1'b0; r.rd = 0; r.ready = 0;
            q.push_front(r);
            void'(q.pop_back());
        end
        @(posedge clk); #1;
        for (int n = 0; n < c_NRAND; n++) begin
            in_t x;
            int  efa, efb;
            bit  na, nb, est;
            rec_t r;
            x = rand_in();
            drive(x);
            m_lookup(x.u1, int'(x.rs1), efa, na);
            m_lookup(x.u2, int'(x.rs2), efb, nb);
            est = x.v && (na || nb);
            @(negedge clk);
            chk("rand stall", 32'(stall), int'(est));
            chk("rand fwd_a", 32'(fwd_a), efa);
            chk("rand fwd_b", 32'(fwd_b), efb);
            chk("rand count", 32'(stall_count), m_cnt);
            @(posedge clk); #1;
            r.v = x.v && !est && !x.fl; r.wr = x.wr; r.rd = int'(x.rd); r.ready = int'(x.rdy);
            q.push_front(r);
            void'(q.pop_back());
            if (est && m_cnt < 65535) m_cnt++;
        end

        // ------------------ DEPTH 5 / CNT_W 2 corner sequences ------------------
        repeat (2) @(posedge clk);
        #1 d2_rst_n = 1'b1;
        d2_cyc(1, 1, 1, 3, 0, 0,  0, 0, 0, "d5 producer");
        d2_cyc(1, 0, 0, 0, 1, 1,  1, -1, 0, "d5 stall1");
        d2_cyc(1, 0, 0, 0, 1, 1,  1, -1, 1, "d5 stall2");
        d2_cyc(1, 0, 0, 0, 1, 1,  1, -1, 2, "d5 stall3");
        d2_cyc(1, 0, 0, 0, 1, 1,  0, 4, 3, "d5 forward");
        d2_cyc(1, 1, 2, 3, 0, 0,  0, 0, 3, "sat producer");
        d2_cyc(1, 0, 0, 0, 1, 2,  1, -1, 3, "sat stall4");
        d2_cyc(1, 0, 0, 0, 1, 2,  1, -1, 3, "sat stall5");
        d2_cyc(1, 0, 0, 0, 1, 2,  1, -1, 3, "sat stall6");
        d2_cyc(1, 0, 0, 0, 1, 2,  0, 4, 3, "sat final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
